// File: rtl/cpu_boot_ctrl_pkg.sv
// Shared types and defaults for the CPU boot/run controller.
package cpu_boot_ctrl_pkg;

   localparam int          XLEN_DEF        = 32;
   localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;
   localparam int          PASS_VALUE      = 1;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } boot_state_e;

   // Counter width that stays legal when the count range collapses to one value.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Byte-stream load port, instruction RAM write port and data-memory store snoop.
interface cpu_boot_ctrl_if
   import cpu_boot_ctrl_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int ADDR_W = 8
);
   logic              ld_valid;
   logic [7:0]        ld_data;
   logic              ld_last;
   logic              ld_ready;

   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [XLEN-1:0]   imem_wdata;

   logic              dmem_we;
   logic [XLEN-1:0]   dmem_addr;
   logic [XLEN-1:0]   dmem_wdata;

   modport slave (
      input  ld_valid, ld_data, ld_last, dmem_we, dmem_addr, dmem_wdata,
      output ld_ready, imem_we, imem_addr, imem_wdata
   );

   modport master (
      output ld_valid, ld_data, ld_last, dmem_we, dmem_addr, dmem_wdata,
      input  ld_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/cpu_boot_ctrl_byte_packer.sv
// Packs accepted bytes little-endian into words and emits one write pulse per word;
// a word closed early by 'last' keeps its unfilled upper bytes at zero.
module cpu_boot_ctrl_byte_packer
   import cpu_boot_ctrl_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int IMEM_DEPTH = 256,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              accept,
   input  logic [7:0]        byte_in,
   input  logic              last,
   output logic              word_we,
   output logic [ADDR_W-1:0] word_addr,
   output logic [XLEN-1:0]   word_data,
   output logic              drop
);
   localparam int              NB       = XLEN / 8;
   localparam int              BC_W     = cnt_width(NB);
   localparam logic [BC_W-1:0] BC_LAST  = BC_W'(NB - 1);
   localparam logic [ADDR_W:0] IDX_FULL = (ADDR_W + 1)'(IMEM_DEPTH);

   logic [BC_W-1:0] byte_cnt;
   logic [XLEN-1:0] shadow;
   logic [XLEN-1:0] merged;
   logic [ADDR_W:0] word_idx;
   logic            full;
   logic            flush;

   // word_idx stops at IMEM_DEPTH, so equality is enough to detect a full RAM.
   assign full  = (word_idx == IDX_FULL);
   assign flush = accept && (last || (byte_cnt == BC_LAST));
   assign drop  = accept && full;

   always_comb begin
      merged = shadow;
      for (int k = 0; k < NB; k++) begin
         if (byte_cnt == BC_W'(k)) merged[8*k +: 8] = byte_in;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         byte_cnt  <= '0;
         shadow    <= '0;
         word_idx  <= '0;
         word_we   <= 1'b0;
         word_addr <= '0;
         word_data <= '0;
      end else begin
         word_we <= 1'b0;
         if (flush) begin
            byte_cnt <= '0;
            shadow   <= '0;
            if (!full) begin
               word_we   <= 1'b1;
               word_addr <= word_idx[ADDR_W-1:0];
               word_data <= merged;
               word_idx  <= word_idx + (ADDR_W + 1)'(1);
            end
         end else if (accept) begin
            byte_cnt <= byte_cnt + BC_W'(1);
            shadow   <= merged;
         end
      end
   end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot and run controller: loads the instruction image with the CPU held in reset,
// releases it, then ends the run on a tohost store or on watchdog expiry.
//
// state | meaning
// LOAD  | accept image bytes, write packed words to instruction RAM
// HOLD  | final word written, CPU still held in reset for RESET_HOLD cycles
// RUN   | CPU released, cycle counter and watchdog active
// DONE  | result captured, CPU frozen until clr
module cpu_boot_ctrl
   import cpu_boot_ctrl_pkg::*;
#(
   parameter int              XLEN        = XLEN_DEF,
   parameter int              IMEM_DEPTH  = 256,
   parameter int              ADDR_W      = $clog2(IMEM_DEPTH),
   parameter int              RESET_HOLD  = 4,
   parameter int              TIMEOUT     = 1000,
   parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEF)
) (
   input  logic        clk,
   input  logic        clr,
   cpu_boot_ctrl_if.slave bus,
   output logic        cpu_clr,
   output logic        done,
   output logic        pass,
   output logic        timed_out,
   output logic        load_err,
   output logic [31:0] cycles
);
   localparam int                HOLD_W    = cnt_width(RESET_HOLD + 2);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_TC   = HOLD_W'(1);
   localparam logic [31:0]       CYC_LIMIT = 32'(TIMEOUT);
   localparam logic [XLEN-1:0]   PASS_WORD = XLEN'(PASS_VALUE);

   boot_state_e       state_q;
   boot_state_e       state_d;
   logic              accept;
   logic              tohost_hit;
   logic              expire;
   logic              pack_drop;
   logic [HOLD_W-1:0] hold_cnt;

   assign bus.ld_ready = (state_q == LOAD) && !clr;
   assign accept       = bus.ld_valid && bus.ld_ready;
   assign cpu_clr      = clr || (state_q != RUN);
   assign tohost_hit   = bus.dmem_we && (bus.dmem_addr == TOHOST_ADDR);
   assign expire       = (cycles == CYC_LIMIT);

   cpu_boot_ctrl_byte_packer #(
      .XLEN       (XLEN),
      .IMEM_DEPTH (IMEM_DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_packer (
      .clk       (clk),
      .clr       (clr),
      .accept    (accept),
      .byte_in   (bus.ld_data),
      .last      (bus.ld_last),
      .word_we   (bus.imem_we),
      .word_addr (bus.imem_addr),
      .word_data (bus.imem_wdata),
      .drop      (pack_drop)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD: if (accept && bus.ld_last) state_d = HOLD;
         HOLD: if (hold_cnt == HOLD_TC)   state_d = RUN;
         RUN:  if (tohost_hit || expire)  state_d = DONE;
         DONE: state_d = DONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= LOAD;
         hold_cnt  <= HOLD_INIT;
         cycles    <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         timed_out <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         state_q <= state_d;

         // The HOLD window includes the cycle carrying the final RAM write.
         if (state_q == LOAD)      hold_cnt <= HOLD_INIT;
         else if (state_q == HOLD) hold_cnt <= hold_cnt - HOLD_W'(1);

         if (state_d == RUN) cycles <= cycles + 32'd1;

         if (pack_drop) load_err <= 1'b1;

         // A tohost store in the expiry cycle takes priority over the watchdog.
         if ((state_q == RUN) && (state_d == DONE)) begin
            done      <= 1'b1;
            pass      <= tohost_hit && (bus.dmem_wdata == PASS_WORD);
            timed_out <= !tohost_hit;
         end
      end
   end

endmodule
